// File: rtl/mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux16_rr_arbiter
// Description : Round-robin arbiter owning the select of a 16:1 mux. Grants
//               one requester at a time, holds ownership until the owner
//               releases (req drop or done) or a hold limit expires while
//               others wait, then rotates priority past the released owner.
// Revision    : 1.0 - initial release
// ============================================================================
module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [3:0]  select,
    output logic [15:0] grant,
    output logic        valid
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_busy  = 1'b1;
    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

    logic [0:0]  state_q,    state_d;
    logic [3:0]  ptr_q,      ptr_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [3:0]  select_q,   select_d;
    logic [15:0] grant_q,    grant_d;
    logic        valid_q,    valid_d;

    logic [31:0] w_req_dbl;
    logic [15:0] w_req_rot;
    logic [3:0]  w_offset;
    logic [3:0]  w_winner;
    logic [15:0] w_owner_mask;
    logic        w_owner_req;
    logic        w_others_req;
    logic        w_release;

    // Winner search: rotate req so ptr lands at bit 0, pick lowest set bit.
    always_comb begin
        w_req_dbl = {req, req};
        w_req_rot = w_req_dbl[ptr_q +: 16];
        w_offset  = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_offset = 4'(k);
            end
        end
        w_winner = ptr_q + w_offset;
    end

    // Release decision for the current owner (only meaningful in BUSY).
    always_comb begin
        w_owner_mask = 16'h0001 << select_q;
        w_owner_req  = |(req & w_owner_mask);
        w_others_req = |(req & ~w_owner_mask);
        w_release    = !w_owner_req || done ||
                       ((hold_cnt_q >= c_max_hold) && w_others_req);
    end

    // Next-state logic for the IDLE/BUSY controller and registered outputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        select_d   = select_q;
        grant_d    = grant_q;
        valid_d    = valid_q;
        case (state_q)
            c_st_idle: begin
                if (req != 16'h0000) begin
                    state_d    = c_st_busy;
                    select_d   = w_winner;
                    grant_d    = 16'h0001 << w_winner;
                    valid_d    = 1'b1;
                    hold_cnt_d = 8'd1;
                end
            end
            default: begin
                if (w_release) begin
                    state_d    = c_st_idle;
                    ptr_d      = select_q + 4'd1;
                    grant_d    = 16'h0000;
                    valid_d    = 1'b0;
                    hold_cnt_d = 8'd0;
                end else if (hold_cnt_q < c_max_hold) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_st_idle;
            ptr_q      <= 4'd0;
            hold_cnt_q <= 8'd0;
            select_q   <= 4'd0;
            grant_q    <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            select_q   <= select_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
        end
    end

    assign select = select_q;
    assign grant  = grant_q;
    assign valid  = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux16_rr_arbiter
// Description : Scoreboard bench for mux16_rr_arbiter with a behavioural
//               reference model of the round-robin ownership rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux16_rr_arbiter;

    localparam int c_max_hold = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [3:0]  select;
    logic [15:0] grant;
    logic        valid;

    mux16_rr_arbiter #(.MAX_HOLD(c_max_hold)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .done   (done),
        .select (select),
        .grant  (grant),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [3:0]  sel;
        logic [15:0] grant;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;

    // Reference model: who owns the mux (-1 = nobody), where the scan starts,
    // how long the owner has held it, and the last select driven.
    int m_owner;
    int m_ptr;
    int m_hold;
    int m_sel;

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_sel   = 0;
    endfunction

    function automatic exp_t model_step(input logic [15:0] r, input logic d);
        exp_t e;
        if (m_owner < 0) begin
            if (r != 16'h0) begin
                for (int k = 0; k < 16; k++) begin
                    int idx;
                    idx = (m_ptr + k) % 16;
                    if (r[idx]) begin
                        m_owner = idx;
                        break;
                    end
                end
                m_sel  = m_owner;
                m_hold = 1;
            end
        end else begin
            int n_others;
            n_others = 0;
            for (int k = 0; k < 16; k++)
                if (r[k] && k != m_owner) n_others++;
            if (!r[m_owner] || d || (m_hold >= c_max_hold && n_others > 0)) begin
                m_ptr   = (m_owner + 1) % 16;
                m_owner = -1;
                m_hold  = 0;
            end else if (m_hold < c_max_hold) begin
                m_hold++;
            end
        end
        e.valid = (m_owner >= 0);
        e.sel   = 4'(m_sel);
        e.grant = (m_owner >= 0) ? (16'h0001 << m_owner) : 16'h0000;
        return e;
    endfunction

    // Apply one cycle of stimulus and queue the outputs expected after the edge.
    task automatic drive(input logic [15:0] r, input logic d);
        @(negedge clk);
        rst_n = 1'b1;
        req   = r;
        done  = d;
        exp_q.push_back(model_step(r, d));
    endtask

    // Asynchronous reset between edges; outputs must clear with no clock.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check({tag, "_valid"},  int'(valid),  0);
        check({tag, "_grant"},  int'(grant),  0);
        check({tag, "_select"}, int'(select), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] pick_req();
        case ($urandom_range(0, 3))
            0: return 16'($urandom);
            1: return 16'h0001 << $urandom_range(0, 15);
            2: return (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            default: return 16'h0000;
        endcase
    endfunction

    // Monitor: the DUT presents outputs every cycle; compare after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("valid",  int'(valid),  int'(e.valid));
                check("select", int'(select), int'(e.sel));
                check("grant",  int'(grant),  int'(e.grant));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cur_req;
        tests = 0;
        fails = 0;
        model_reset();

        // Reset held with every request asserted.
        rst_n = 1'b0;
        req   = 16'hFFFF;
        done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",  int'(valid),  0);
        check("rst_grant",  int'(grant),  0);
        check("rst_select", int'(select), 0);
        req = 16'h0000;

        // Single requester: no rotation, then done releases.
        for (int i = 0; i < 22; i++) drive(16'h0020, 1'b0);
        drive(16'h0020, 1'b1);
        drive(16'h0000, 1'b0);
        drive(16'h0000, 1'b0);

        // Two requesters with wrap-around from 15 to 0.
        async_reset("rst_mid1");
        for (int i = 0; i < 40; i++) drive(16'h8001, 1'b0);

        // Full contention, owner finishes on its first cycle.
        async_reset("rst_mid2");
        for (int i = 0; i < 36; i++)
            drive(16'hFFFF, (m_owner >= 0 && m_hold == 1));

        // Release of owner 3 while requester 2 appears with ptr at 3.
        async_reset("rst_mid3");
        drive(16'h0004, 1'b0);
        drive(16'h0004, 1'b0);
        drive(16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) drive(16'h0008, 1'b0);
        for (int i = 0; i < 4; i++) drive(16'h0004, 1'b0);

        // Hold limit reached alone, then a late arrival forces rotation.
        async_reset("rst_mid4");
        for (int i = 0; i < 29; i++) drive(16'h0080, 1'b0);
        for (int i = 0; i < 15; i++) drive(16'h0082, 1'b0);

        // Random traffic with sticky request patterns.
        async_reset("rst_mid5");
        cur_req = 16'h0000;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) cur_req = pick_req();
            drive(cur_req, ($urandom_range(0, 9) == 0));
        end

        // Outputs must be checked for every queued expectation.
        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux16_rr_arbiter.md
# mux16_rr_arbiter

Round-robin arbiter that shares the 16-input `mux16to1` datapath among 16 requesters. Each cycle it decides which requester owns the mux and drives the 4-bit `select` to the mux, plus a one-hot grant back to the requesters. Ownership is held until the owner releases or a hold limit expires while others wait, so no requester starves. It sits directly in front of `mux16to1`: `select` connects to the mux select input, and requester `i` drives mux data input `d[i]`.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive granted cycles before forced rotation when another request is pending. Legal range is 1..255.
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  16  request line per requester; `req[i]` belongs to mux input `d[i]`.
- `done`  input  1  the current owner signals its last cycle of use.
- `select`  output  4  mux select, which is the index of the owner. Registered.
- `grant`  output  16  one-hot grant; equals `1<<select` when `valid`, else 0. Registered.
- `valid`  output  1  high while an owner holds the mux. Registered.

## Operation
- Internal state:
  - FSM: IDLE, BUSY.
  - `ptr[3:0]`: priority start index.
  - `hold_cnt[7:0]`: cycles the current owner has held the mux.
- IDLE:
  - If `req`==0, stay in IDLE. Outputs are `valid`=0, `grant`=0, and `select` keeps its last value.
  - Else the winner is the first index `w` with `req[w]`=1, scanning `ptr`, `ptr+1`, …, `ptr+15` modulo 16 (wrap from 15 to 0).
  - Next edge: go to BUSY with `select`=w, `grant`=1<<w, `valid`=1, `hold_cnt`=1.
- BUSY, with owner `o`=`select`. Release the owner when any of the following holds:
  - `req[o]`=0, or
  - `done`=1, or
  - `hold_cnt`>=`MAX_HOLD` and `(req & ~(1<<o))`!=0.
- On release, the next edge does all of: go to IDLE, set `ptr`=o+1 mod 16, `valid`=0, `grant`=0, `hold_cnt`=0.
- Without release: stay in BUSY, `hold_cnt` increments, saturating at `MAX_HOLD`. A sole requester keeps ownership indefinitely.
- `select` never changes while `valid`=1.
- Reset (async, any time, including mid-grant) forces:
  - state IDLE
  - `ptr`=0
  - `hold_cnt`=0
  - `select`=4'b0000
  - `grant`=16'h0000
  - `valid`=0
- Reset deassertion: the first edge with `rst_n`=1 performs a normal IDLE arbitration.

## Timing
- Grant latency: a request sampled at edge k in IDLE is granted with outputs visible after edge k. This is one cycle from request to grant.
- Release takes one cycle, and the mux is idle for exactly one cycle between owners. Back-to-back handover is therefore `valid` low for one cycle, then the new grant.
- Timing of `done` and `req` drop:
  - `done` or a `req[o]` drop sampled at edge k causes `valid`=0 after edge k.
  - The owner therefore gets the mux during the cycle in which it asserts `done`.
- Forced rotation: with others waiting, the owner holds exactly `MAX_HOLD` cycles of `valid`.
- Simultaneous events:
  - `done` together with a new request from another index: release has priority. The new request wins at the following IDLE arbitration.
  - A request from the owner itself reasserted after release competes normally, with the lowest priority because `ptr` is now o+1.
- Changes on `req` while in BUSY (other than `req[o]`) do not affect outputs until the next IDLE cycle.

## Test plan
- **Reset values:** hold `rst_n`=0, apply `req`=16'hFFFF → `select`=0, `grant`=0, `valid`=0. Pulse `rst_n` low mid-grant → all outputs clear immediately, without waiting for a clock edge.
- **Single requester:** after reset, `req`=16'h0020 → one edge later `select`=5, `grant`=16'h0020, `valid`=1. Hold `req` for 20 cycles → `valid` stays 1 (no rotation). Pulse `done` → `valid`=0 next edge.
- **Round robin with wrap-around:**
  - `req`=16'h8001 held, `MAX_HOLD`=8, after reset → grants go 0, then 15, then 0, and so on.
  - Each grant lasts 8 cycles, separated by 1 idle cycle.
  - The `select` sequence is 0, 15, 0.
- **Full contention:** `req`=16'hFFFF with `done` pulsed on each owner's first cycle → `select` visits 0, 1, 2, …, 15, 0 in order, alternating 1 cycle granted and 1 cycle idle.
- **Release versus new request:** owner 3 drops `req[3]` in the same cycle that `req[2]` rises (`ptr` was 3) → idle cycle, then `select`=2 (the scan starts at `ptr`=4 and wraps around to 2).
- **Hold limit with late arrival:**
  - Owner 7 is granted alone, `hold_cnt` saturates at 8.
  - `req[1]` rises at cycle 30 → 7 is released at the next edge, then after 1 idle cycle `select`=1.
